// File: rtl/rr_read_arbiter_if.sv
// Bus bundle for the four-port round-robin read arbiter: requester side
// (request/address/data/ready) plus the shared synchronous memory port.
interface rr_read_arbiter_if #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int DATA_WIDTH    = 8
);
  logic [3:0]                 data_req;
  logic [4*ADDRESS_WIDTH-1:0] data_addr;
  logic [4*DATA_WIDTH-1:0]    data;
  logic [3:0]                 data_rdy;
  logic [ADDRESS_WIDTH-1:0]   mem_data_addr;
  logic [DATA_WIDTH-1:0]      mem_data;
  logic                       busy;

  modport slave (
    input  data_req, data_addr, mem_data,
    output data, data_rdy, mem_data_addr, busy
  );

  modport master (
    output data_req, data_addr, mem_data,
    input  data, data_rdy, mem_data_addr, busy
  );
endinterface

// File: rtl/rr_read_arbiter.sv
// Four-port round-robin arbiter sharing one synchronous-read memory.
// Each read takes two cycles (ADDR, CAPTURE); grants chain back-to-back.
module rr_read_arbiter #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int DATA_WIDTH    = 8
) (
  input  logic               clk,
  input  logic               rst,
  rr_read_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, ADDR, CAPTURE} state_t;

  state_t                     r_state;
  state_t                     w_next;
  logic [1:0]                 r_grant;
  logic [1:0]                 r_last_grant;
  logic [ADDRESS_WIDTH-1:0]   r_mem_addr;
  logic [4*DATA_WIDTH-1:0]    r_data;
  logic [3:0]                 r_rdy;

  logic [3:0]                 w_cand;
  logic [1:0]                 w_idx;
  logic [1:0]                 w_winner;
  logic                       w_found;
  logic                       w_do_grant;

  // Port being captured this edge is excluded so another requester can be
  // chained without re-serving the one just completed.
  always_comb begin
    w_found  = 1'b0;
    w_winner = r_last_grant;
    w_idx    = r_last_grant;
    w_cand   = bus.data_req & ~r_rdy;
    if (r_state == CAPTURE) w_cand[r_grant] = 1'b0;
    for (int unsigned k = 1; k <= 4; k++) begin
      w_idx = r_last_grant + 2'(k);
      if (!w_found && w_cand[w_idx]) begin
        w_found  = 1'b1;
        w_winner = w_idx;
      end
    end
  end

  always_comb begin
    w_next     = r_state;
    w_do_grant = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_found) begin
          w_next     = ADDR;
          w_do_grant = 1'b1;
        end
      end
      ADDR: w_next = CAPTURE;
      CAPTURE: begin
        if (w_found) begin
          w_next     = ADDR;
          w_do_grant = 1'b1;
        end else begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_grant      <= '0;
      r_last_grant <= 2'd3;
      r_mem_addr   <= '0;
    end else begin
      r_state <= w_next;
      if (w_do_grant) begin
        r_grant      <= w_winner;
        r_last_grant <= w_winner;
        r_mem_addr   <= bus.data_addr[int'(w_winner)*ADDRESS_WIDTH +: ADDRESS_WIDTH];
      end
    end
  end

  // Ready clears on any edge with the request low; an aborted capture
  // therefore leaves both ready and the data slice untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data <= '0;
      r_rdy  <= '0;
    end else begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (!bus.data_req[i]) begin
          r_rdy[i] <= 1'b0;
        end else if (r_state == CAPTURE && r_grant == 2'(i)) begin
          r_rdy[i] <= 1'b1;
          r_data[i*DATA_WIDTH +: DATA_WIDTH] <= bus.mem_data;
        end
      end
    end
  end

  assign bus.data          = r_data;
  assign bus.data_rdy      = r_rdy;
  assign bus.mem_data_addr = r_mem_addr;
  assign bus.busy          = (r_state != IDLE);

endmodule

// File: tb/tb_rr_read_arbiter.sv
// Self-checking bench: directed scenarios with literal expectations plus a
// randomized four-phase requester run against a transaction-level model.
module tb_rr_read_arbiter;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_fail;

  rr_read_arbiter_if #(.ADDRESS_WIDTH(8), .DATA_WIDTH(8)) bus ();

  rr_read_arbiter #(.ADDRESS_WIDTH(8), .DATA_WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous memory: contents are address ^ 0xFF, one-cycle read latency.
  always @(posedge clk) bus.mem_data <= bus.mem_data_addr ^ 8'hFF;

  // Transaction-level model: a read occupies the two edges after its grant;
  // m_left counts edges remaining until its capture edge.
  logic [3:0] m_rdy;
  logic [7:0] m_data [4];
  logic [7:0] m_addr;
  int         m_port;
  int         m_last;
  int         m_left;

  always @(posedge clk or posedge rst) begin
    logic [3:0] req;
    logic [3:0] nrdy;
    logic       cap;
    logic       found;
    int         nleft;
    int         p;
    if (rst) begin
      m_rdy  = '0;
      for (int i = 0; i < 4; i++) m_data[i] = '0;
      m_addr = '0;
      m_port = 0;
      m_last = 3;
      m_left = 0;
    end else begin
      req   = bus.data_req;
      cap   = (m_left == 1);
      nrdy  = m_rdy;
      for (int i = 0; i < 4; i++) if (!req[i]) nrdy[i] = 1'b0;
      if (cap && req[m_port]) begin
        nrdy[m_port]   = 1'b1;
        m_data[m_port] = m_addr ^ 8'hFF;
      end
      nleft = (m_left == 2) ? 1 : 0;
      found = 1'b0;
      if (m_left == 0 || cap) begin
        for (int k = 1; k <= 4; k++) begin
          p = (m_last + k) % 4;
          if (!found && req[p] && !m_rdy[p] && !(cap && p == m_port)) begin
            found  = 1'b1;
            m_port = p;
            m_last = p;
            m_addr = bus.data_addr[p*8 +: 8];
            nleft  = 2;
          end
        end
      end
      m_rdy  = nrdy;
      m_left = nleft;
    end
  end

  always @(negedge clk) begin
    logic [31:0] exp_d;
    for (int i = 0; i < 4; i++) exp_d[i*8 +: 8] = m_data[i];
    n_cmp++;
    if (bus.data_rdy !== m_rdy) begin
      n_fail++;
      $display("FAIL model_rdy t=%0t got=%b exp=%b", $time, bus.data_rdy, m_rdy);
    end
    n_cmp++;
    if (bus.data !== exp_d) begin
      n_fail++;
      $display("FAIL model_data t=%0t got=%h exp=%h", $time, bus.data, exp_d);
    end
    n_cmp++;
    if (bus.mem_data_addr !== m_addr) begin
      n_fail++;
      $display("FAIL model_addr t=%0t got=%h exp=%h", $time, bus.mem_data_addr, m_addr);
    end
    n_cmp++;
    if (bus.busy !== (m_left != 0)) begin
      n_fail++;
      $display("FAIL model_busy t=%0t got=%b exp=%b", $time, bus.busy, (m_left != 0));
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t got=%h exp=%h", name, $time, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string name);
    chk({name, "_rdy"},  32'(bus.data_rdy), 32'h0);
    chk({name, "_busy"}, 32'(bus.busy), 32'h0);
    chk({name, "_addr"}, 32'(bus.mem_data_addr), 32'h0);
    chk({name, "_data"}, bus.data, 32'h0);
  endtask

  // Called at a drive point (posedge+2); returns at a drive point.
  task automatic do_reset();
    bus.data_req  = '0;
    bus.data_addr = '0;
    rst = 1'b1;
    #1;
    chk_zero("reset");
    tick();
    #1;
    rst = 1'b0;
  endtask

  initial begin
    logic [31:0] d;
    logic [7:0]  fair_exp [4];
    n_cmp  = 0;
    n_fail = 0;
    rst    = 1'b0;
    bus.data_req  = '0;
    bus.data_addr = '0;
    #2;
    do_reset();

    // Single read
    bus.data_req  = 4'b0001;
    bus.data_addr = 32'h0000_0012;
    tick(); chk("single_addr", 32'(bus.mem_data_addr), 32'h12);
            chk("single_busy", 32'(bus.busy), 32'h1);
    #1; tick();
    #1; tick(); chk("single_rdy", 32'(bus.data_rdy), 32'h1);
    d = bus.data; chk("single_data", 32'(d[7:0]), 32'hED);
    chk("single_idle", 32'(bus.busy), 32'h0);
    #1; bus.data_req = '0;
    tick(); chk("single_clear", 32'(bus.data_rdy), 32'h0);
    d = bus.data; chk("single_hold", 32'(d[7:0]), 32'hED);
    #1;

    // All four ports at once
    do_reset();
    bus.data_req  = 4'b1111;
    bus.data_addr = 32'h1312_1110;
    for (int e = 0; e <= 8; e++) begin
      tick();
      if (e == 0) chk("all_grant0", 32'(bus.mem_data_addr), 32'h10);
      if (e == 2) chk("all_grant1", 32'(bus.mem_data_addr), 32'h11);
      if (e == 4) chk("all_grant2", 32'(bus.mem_data_addr), 32'h12);
      if (e == 6) chk("all_grant3", 32'(bus.mem_data_addr), 32'h13);
      if (e == 2) chk("all_rdy_e2", 32'(bus.data_rdy), 32'b0001);
      if (e == 4) chk("all_rdy_e4", 32'(bus.data_rdy), 32'b0011);
      if (e == 6) chk("all_rdy_e6", 32'(bus.data_rdy), 32'b0111);
      if (e == 8) chk("all_rdy_e8", 32'(bus.data_rdy), 32'b1111);
      if (e < 8)  chk("all_busy", 32'(bus.busy), 32'h1);
      #1;
    end
    chk("all_data", bus.data, 32'hECED_EEEF);
    bus.data_req = '0;

    // Fairness between ports 0 and 2
    do_reset();
    bus.data_addr = 32'h0052_0050;
    bus.data_req  = 4'b0101;
    fair_exp[0] = 8'h50; fair_exp[1] = 8'h52; fair_exp[2] = 8'h50; fair_exp[3] = 8'h52;
    for (int s = 0; s < 8; s++) begin
      tick();
      if (s % 2 == 0) chk("fair_grant", 32'(bus.mem_data_addr), 32'(fair_exp[s/2]));
      #1;
      for (int pi = 0; pi < 4; pi += 2) begin
        if (bus.data_req[pi] && bus.data_rdy[pi]) bus.data_req[pi] = 1'b0;
        else if (!bus.data_req[pi] && !bus.data_rdy[pi]) bus.data_req[pi] = 1'b1;
      end
    end
    bus.data_req = '0;

    // Abort during ADDR
    do_reset();
    bus.data_req  = 4'b0010;
    bus.data_addr = 32'h0000_4000;
    tick(); chk("abort_grant", 32'(bus.mem_data_addr), 32'h40);
    #1; bus.data_req = '0;
    tick(); chk("abort_busy", 32'(bus.busy), 32'h1);
    #1; tick();
    chk("abort_rdy", 32'(bus.data_rdy), 32'h0);
    d = bus.data; chk("abort_data", 32'(d[15:8]), 32'h0);
    chk("abort_idle", 32'(bus.busy), 32'h0);
    #1;

    // Async reset during CAPTURE
    do_reset();
    bus.data_req  = 4'b0001;
    bus.data_addr = 32'h0000_0020;
    tick(); #1; tick();
    chk("capt_busy", 32'(bus.busy), 32'h1);
    #1;
    rst = 1'b1;
    #1;
    chk_zero("async");
    #1;
    rst = 1'b0;
    bus.data_req  = 4'b1100;
    bus.data_addr = 32'h3130_0000;
    tick(); chk("post_rst_grant", 32'(bus.mem_data_addr), 32'h30);
    #1; tick();
    #1; tick(); chk("post_rst_rdy", 32'(bus.data_rdy), 32'b0100);
    #1;
    bus.data_req = '0;
    do_reset();

    // Randomized four-phase requesters with occasional aborts and resets
    for (int c = 0; c < 4000; c++) begin
      tick();
      #1;
      if (rst) rst = 1'b0;
      else if ($urandom_range(0, 499) == 0) rst = 1'b1;
      for (int pi = 0; pi < 4; pi++) begin
        if (bus.data_req[pi]) begin
          if (bus.data_rdy[pi]) begin
            if ($urandom_range(0, 3) != 0) bus.data_req[pi] = 1'b0;
          end else if ($urandom_range(0, 39) == 0) begin
            bus.data_req[pi] = 1'b0;
          end else if ($urandom_range(0, 19) == 0) begin
            bus.data_addr[pi*8 +: 8] = 8'($urandom);
          end
        end else if (!bus.data_rdy[pi] && $urandom_range(0, 2) == 0) begin
          bus.data_req[pi] = 1'b1;
          bus.data_addr[pi*8 +: 8] = 8'($urandom);
        end
      end
    end
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/rr_read_arbiter.md
RR_READ_ARBITER -- requirements
Module: rr_read_arbiter

Interface
REQ-001 The block SHALL have parameter ADDRESS_WIDTH, default 8, memory address width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 8, memory data width.
REQ-003 The block SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 The block SHALL have port data_req  input  4  per-port read request, bit i = port i.
REQ-006 The block SHALL have port data_addr  input  4*ADDRESS_WIDTH  port i address in bits [i*ADDRESS_WIDTH +: ADDRESS_WIDTH].
REQ-007 The block SHALL have port data  output  4*DATA_WIDTH  port i read data in bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 The block SHALL have port data_rdy  output  4  per-port data-valid flag.
REQ-009 The block SHALL have port mem_data_addr  output  ADDRESS_WIDTH  registered address to shared synchronous memory.
REQ-010 The block SHALL have port mem_data  input  DATA_WIDTH  memory read data, valid one cycle after mem_data_addr is presented.
REQ-011 The block SHALL have port busy  output  1  high whenever the FSM is not IDLE.

Function
REQ-012 Handshake per port SHALL be four-phase: requester raises data_req[i] and holds data_addr slice stable; the block sets data_rdy[i] with data valid; requester drops data_req[i]; the block clears data_rdy[i] on the next edge.
REQ-013 Port i SHALL be outstanding when data_req[i]=1 and data_rdy[i]=0.
REQ-014 The FSM SHALL have states IDLE, ADDR, CAPTURE.
REQ-015 In IDLE with any port outstanding, the next edge SHALL register the winner in grant, load mem_data_addr with its address, and enter ADDR; with none outstanding the FSM SHALL stay in IDLE.
REQ-016 The winner SHALL be the first outstanding port in order last_grant+1, +2, +3, +4 (mod 4); last_grant SHALL update to the winner at each grant.
REQ-017 ADDR SHALL always advance to CAPTURE on the next edge (memory samples mem_data_addr at this edge).
REQ-018 On the CAPTURE edge, if data_req[grant] is still 1, the block SHALL latch mem_data into the grant data slice and set data_rdy[grant]=1.
REQ-019 On the CAPTURE edge, if data_req[grant] is 0 (aborted), the block SHALL leave the data slice and data_rdy[grant] unchanged (both 0/stale).
REQ-020 From CAPTURE, if any port other than grant is outstanding, the block SHALL grant it per REQ-016 on the same edge and enter ADDR (back-to-back, 2 cycles per read); otherwise it SHALL enter IDLE.
REQ-021 Latency: data_req[i] sampled high at edge E0 with the block IDLE SHALL yield data_rdy[i]=1 after edge E2.
REQ-022 mem_data_addr SHALL change only at a grant edge and otherwise hold its last value; data_addr changes after grant SHALL be ignored.
REQ-023 data_rdy[i] SHALL clear on any edge where data_req[i]=0, independent of FSM state; the data slice SHALL hold its value.
REQ-024 A port SHALL not be regranted while data_rdy[i]=1; after the drop/clear it SHALL re-arbitrate normally.
REQ-025 Only one port SHALL be served at a time; simultaneous requests SHALL be serialized strictly by REQ-016.
REQ-026 busy SHALL be 1 in ADDR and CAPTURE and 0 in IDLE.

Reset
REQ-027 Asserting rst SHALL immediately, without a clock edge, force state=IDLE, grant=0, last_grant=3, mem_data_addr=0, data=0, data_rdy=0, busy=0.
REQ-028 Reset mid-transaction SHALL abandon the read; no data_rdy SHALL assert for it after rst deasserts.
REQ-029 After rst deasserts, the first edge with outstanding requests SHALL grant per REQ-016 from last_grant=3 (port 0 first).

Verification
REQ-030 Single read: after reset, data_req=0001, addr0=0x12, memory returns 0x12^0xFF -> mem_data_addr=0x12 after E0, data_rdy=0001 and data[7:0]=0xED after E2.
REQ-031 All four ports request at once, addresses 0x10..0x13 -> grants in order 0,1,2,3, data_rdy bits set after E2, E4, E6, E8; busy high continuously E0..E8.
REQ-032 Fairness: port 0 re-requests immediately after each completion while port 2 requests -> grants alternate 0,2,0,2; port 2 is never starved.
REQ-033 Abort: port 1 drops data_req in ADDR -> data_rdy[1] stays 0, data[15:8] unchanged, FSM returns to IDLE after CAPTURE.
REQ-034 Async reset: assert rst mid-cycle while in CAPTURE -> outputs zero before the next edge; release, requests 1100 -> port 2 granted first.
